// File: rtl/cpu_id.sv
// ---------------------------------------------------------------------------
// cpu_id -- instruction-decode stage of the 5-stage MIPS pipeline.
//
// Takes the registered IF outputs, splits the instruction into its fields,
// extends the immediate, and reads the 32x32 GPR file. The GPR file is written
// by WB. Every output comes straight from a flop, so the stage has exactly one
// cycle of latency.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : a WB write on the same edge as the read is forwarded into
//               rs_data / rt_data, and into the $v0 value used for the
//               syscall-halt check.
//   undefined : the same-edge read returns the old GPR value. The hazard unit
//               has to stall one extra cycle to cover this.
//
// Parameters
//   HALT_V0   value of $v0 ($2) that turns a syscall into a halt
//   RESET_PC  value of pc_out after reset
//
// Ports
//   clk, clr                     clock and synchronous active-high reset
//   pc_in, ins_in,
//   cycle_count_in, halt_in      IF stage outputs
//   stall                        hold all ID outputs this cycle
//   flush                        replace the incoming instruction with a bubble
//   wb_en, wb_addr, wb_data      GPR write port, driven by WB
//   pc_out, ins_out, cycle_count registered copies of the IF values
//   opcode, funct, rs_addr,
//   rt_addr, rd_addr, shamt      decoded instruction fields
//   imm_ext                      extended immediate
//   rs_data, rt_data             GPR read data
//   valid                        1 = real instruction, 0 = bubble
//   halt                         sticky halt flag, cleared only by clr
// ---------------------------------------------------------------------------
module cpu_id #(
   parameter logic [31:0] HALT_V0  = 32'd10,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] pc_in,
   input  logic [31:0] ins_in,
   input  logic [31:0] cycle_count_in,
   input  logic        halt_in,
   input  logic        stall,
   input  logic        flush,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic [31:0] pc_out,
   output logic [31:0] ins_out,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   output logic [4:0]  rd_addr,
   output logic [4:0]  shamt,
   output logic [31:0] imm_ext,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   output logic        valid,
   output logic [31:0] cycle_count,
   output logic        halt
);

   // Halt FSM encoding
   localparam logic [0:0] S_RUN    = 1'b0;
   localparam logic [0:0] S_HALTED = 1'b1;

   localparam logic [5:0] OP_SPECIAL  = 6'h00;
   localparam logic [5:0] OP_ANDI     = 6'h0C;
   localparam logic [5:0] OP_ORI      = 6'h0D;
   localparam logic [5:0] OP_XORI     = 6'h0E;
   localparam logic [5:0] FN_SYSCALL  = 6'h0C;

   logic [0:0]  state;
   logic [31:0] gpr [0:31];

   // Incoming instruction fields
   logic [5:0]  in_op;
   logic [5:0]  in_fn;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [15:0] in_imm;

   assign in_op  = ins_in[31:26];
   assign in_fn  = ins_in[5:0];
   assign in_rs  = ins_in[25:21];
   assign in_rt  = ins_in[20:16];
   assign in_imm = ins_in[15:0];

   // Writes to $0 are dropped.
   logic wb_live;
   assign wb_live = wb_en && (wb_addr != 5'd0);

   // GPR read ports. $0 is forced to zero here rather than relying on the
   // storage, so its value holds even before the first clr.
   logic [31:0] rs_rd, rt_rd, v0_rd;

   always_comb begin
      rs_rd = (in_rs == 5'd0) ? 32'd0 : gpr[in_rs];
      rt_rd = (in_rt == 5'd0) ? 32'd0 : gpr[in_rt];
      v0_rd = gpr[2];
`ifdef WB_BYPASS_EN
      if (wb_live && wb_addr == in_rs) rs_rd = wb_data;
      if (wb_live && wb_addr == in_rt) rt_rd = wb_data;
      if (wb_live && wb_addr == 5'd2)  v0_rd = wb_data;
`endif
   end

   // andi/ori/xori take a zero-extended immediate. Every other opcode
   // sign-extends, so branch offsets and lw/sw displacements work as expected.
   logic [31:0] imm_next;

   always_comb begin
      if (in_op == OP_ANDI || in_op == OP_ORI || in_op == OP_XORI)
         imm_next = {16'h0000, in_imm};
      else
         imm_next = {{16{in_imm[15]}}, in_imm};
   end

   // What happens to the ID/EX register this cycle. A halted stage freezes
   // completely, and it ignores flush as well, so the halting syscall stays
   // visible on ins_out.
   logic running, do_flush, do_load, sys_halt;

   assign running  = (state == S_RUN);
   assign do_flush = running && flush;
   assign do_load  = running && !flush && !stall;
   assign sys_halt = do_load && (in_op == OP_SPECIAL) && (in_fn == FN_SYSCALL)
                     && (v0_rd == HALT_V0);

   // The halt flag comes straight from the state flop. It rises on the same
   // edge that loads the syscall into ins_out.
   assign halt = state[0];

   always_ff @(posedge clk) begin
      if (clr) begin
         state       <= S_RUN;
         pc_out      <= RESET_PC;
         ins_out     <= 32'd0;
         opcode      <= 6'd0;
         funct       <= 6'd0;
         rs_addr     <= 5'd0;
         rt_addr     <= 5'd0;
         rd_addr     <= 5'd0;
         shamt       <= 5'd0;
         imm_ext     <= 32'd0;
         rs_data     <= 32'd0;
         rt_data     <= 32'd0;
         valid       <= 1'b0;
         cycle_count <= 32'd1;
         for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
      end else begin
         // WB writes keep committing during stall and halt, so the pipeline
         // behind this stage can drain.
         if (wb_live) gpr[wb_addr] <= wb_data;

         if (do_flush) begin
            // Bubble: the PC and cycle count still follow IF. Everything
            // that describes the instruction is cleared.
            pc_out      <= pc_in;
            ins_out     <= 32'd0;
            opcode      <= 6'd0;
            funct       <= 6'd0;
            rs_addr     <= 5'd0;
            rt_addr     <= 5'd0;
            rd_addr     <= 5'd0;
            shamt       <= 5'd0;
            imm_ext     <= 32'd0;
            rs_data     <= 32'd0;
            rt_data     <= 32'd0;
            valid       <= 1'b0;
            cycle_count <= cycle_count_in;
         end else if (do_load) begin
            pc_out      <= pc_in;
            ins_out     <= ins_in;
            opcode      <= in_op;
            funct       <= in_fn;
            rs_addr     <= in_rs;
            rt_addr     <= in_rt;
            rd_addr     <= ins_in[15:11];
            shamt       <= ins_in[10:6];
            imm_ext     <= imm_next;
            rs_data     <= rs_rd;
            rt_data     <= rt_rd;
            valid       <= 1'b1;
            cycle_count <= cycle_count_in;
         end

         if (running && (halt_in || sys_halt)) state <= S_HALTED;
      end
   end

endmodule

// File: tb/tb_cpu_id.sv
module tb_cpu_id;

   localparam logic [31:0] HALT_V0  = 32'd10;
   localparam logic [31:0] RESET_PC = 32'd0;

   logic        clk = 1'b0;
   logic        clr, halt_in, stall, flush, wb_en;
   logic [31:0] pc_in, ins_in, cycle_count_in, wb_data;
   logic [4:0]  wb_addr;
   logic [31:0] pc_out, ins_out, imm_ext, rs_data, rt_data, cycle_count;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
   logic        valid, halt;

   always #5 clk = ~clk;

   cpu_id #(.HALT_V0(HALT_V0), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .clr(clr), .pc_in(pc_in), .ins_in(ins_in),
      .cycle_count_in(cycle_count_in), .halt_in(halt_in),
      .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .pc_out(pc_out), .ins_out(ins_out),
      .opcode(opcode), .funct(funct), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rd_addr(rd_addr), .shamt(shamt), .imm_ext(imm_ext),
      .rs_data(rs_data), .rt_data(rt_data), .valid(valid),
      .cycle_count(cycle_count), .halt(halt)
   );

   // Reference model: architectural register file, halted flag and the
   // expected contents of the ID/EX register.
   logic [31:0] m_gpr [32];
   logic        m_halted;
   logic [31:0] e_pc, e_ins, e_imm, e_rs, e_rt, e_cc;
   logic        e_valid;
   bit          cc_known;
   int          n_pass = 0;
   int          n_total = 0;

   function automatic logic [31:0] rd_gpr(logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
      if (wb_en && wb_addr == a) return wb_data;
`endif
      return m_gpr[a];
   endfunction

   // Apply one clock edge to the model, using the inputs that are present
   // before the edge.
   task automatic model_edge();
      logic [31:0] rv, tv, v0;
      logic [5:0]  op;
      if (clr) begin
         for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
         m_halted = 1'b0;
         e_pc = RESET_PC; e_ins = 0; e_imm = 0; e_rs = 0; e_rt = 0;
         e_cc = 32'd1; e_valid = 1'b0; cc_known = 1;
         return;
      end
      rv = rd_gpr(ins_in[25:21]);
      tv = rd_gpr(ins_in[20:16]);
      v0 = rd_gpr(5'd2);
      if (!m_halted) begin
         if (flush) begin
            e_pc = pc_in; e_ins = 0; e_imm = 0; e_rs = 0; e_rt = 0;
            e_valid = 1'b0; cc_known = 0;
         end else if (!stall) begin
            op = ins_in[31:26];
            e_pc = pc_in; e_ins = ins_in; e_rs = rv; e_rt = tv;
            e_cc = cycle_count_in; e_valid = 1'b1; cc_known = 1;
            if (op == 6'h0C || op == 6'h0D || op == 6'h0E)
               e_imm = {16'h0, ins_in[15:0]};
            else
               e_imm = {{16{ins_in[15]}}, ins_in[15:0]};
            if (op == 6'h00 && ins_in[5:0] == 6'h0C && v0 == HALT_V0)
               m_halted = 1'b1;
         end
         if (halt_in) m_halted = 1'b1;
      end
      if (wb_en && wb_addr != 5'd0) m_gpr[wb_addr] = wb_data;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("pc_out",  pc_out,  e_pc);
      chk("ins_out", ins_out, e_ins);
      chk("opcode",  {26'd0, opcode},  {26'd0, e_ins[31:26]});
      chk("funct",   {26'd0, funct},   {26'd0, e_ins[5:0]});
      chk("rs_addr", {27'd0, rs_addr}, {27'd0, e_ins[25:21]});
      chk("rt_addr", {27'd0, rt_addr}, {27'd0, e_ins[20:16]});
      chk("rd_addr", {27'd0, rd_addr}, {27'd0, e_ins[15:11]});
      chk("shamt",   {27'd0, shamt},   {27'd0, e_ins[10:6]});
      chk("imm_ext", imm_ext, e_imm);
      chk("rs_data", rs_data, e_rs);
      chk("rt_data", rt_data, e_rt);
      chk("valid",   {31'd0, valid}, {31'd0, e_valid});
      chk("halt",    {31'd0, halt},  {31'd0, m_halted});
      if (cc_known) chk("cycle_count", cycle_count, e_cc);
   endtask

   // One clock: update the model, let the edge happen, then check away from
   // the edge. Inputs change only after the check.
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
      cycle_count_in = cycle_count_in + 1;
   endtask

   initial begin
      logic [31:0] r;
      logic [5:0]  ops [6];
      ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h0C;
      ops[3] = 6'h0D; ops[4] = 6'h0E; ops[5] = 6'h23;
      clr = 1; halt_in = 0; stall = 0; flush = 0; wb_en = 0;
      wb_addr = 0; wb_data = 0; pc_in = 32'h100; ins_in = 32'h0;
      cycle_count_in = 32'd5;
      #2;

      // Reset held for two cycles
      step(); step();
      chk("rst_pc", pc_out, 32'd0);
      chk("rst_cc", cycle_count, 32'd1);
      chk("rst_valid_halt", {30'd0, valid, halt}, 32'd0);
      clr = 0;

      // After release, GPR reads return 0
      ins_in = 32'h012A5820; pc_in = 32'h0;
      step();
      chk("post_rst_rs", rs_data, 32'd0);

      // Write $8, then add $10,$8,$9 reads it back
      wb_en = 1; wb_addr = 5'd8; wb_data = 32'h1234; ins_in = 32'h0; pc_in = 32'h4;
      step();
      wb_en = 0; ins_in = 32'h01095020; pc_in = 32'h8;
      step();
      chk("add_rs_addr", {27'd0, rs_addr}, 32'd8);
      chk("add_rd_addr", {27'd0, rd_addr}, 32'd10);
      chk("add_rs_data", rs_data, 32'h1234);
      chk("add_valid", {31'd0, valid}, 32'd1);

      // Immediate extension: addi sign-extends, ori zero-extends
      ins_in = 32'h2008FFFF; step();
      chk("addi_imm", imm_ext, 32'hFFFFFFFF);
      ins_in = 32'h3408FFFF; step();
      chk("ori_imm", imm_ext, 32'h0000FFFF);

      // Stall for three cycles while IF keeps changing
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         ins_in = $urandom; pc_in = $urandom; step();
      end
      chk("stall_hold", ins_out, 32'h3408FFFF);
      flush = 1; step();
      chk("stall_flush_valid", {31'd0, valid}, 32'd0);
      chk("stall_flush_ins", ins_out, 32'd0);
      stall = 0; flush = 0;

      // Same-edge write of $9 while the instruction reads $9
      wb_en = 1; wb_addr = 5'd9; wb_data = 32'hAA; ins_in = 32'h01095020;
      step();
`ifdef WB_BYPASS_EN
      chk("same_edge_rt", rt_data, 32'hAA);
`else
      chk("same_edge_rt", rt_data, 32'h0);
`endif
      // A write to $0 is discarded
      wb_addr = 5'd0; wb_data = 32'hFFFF; ins_in = 32'h0;
      step();
      wb_en = 0; ins_in = 32'h00004020;
      step();
      chk("zero_reg", rs_data, 32'd0);

      // Random traffic, with opcodes biased toward the interesting ones
      for (int n = 0; n < 400; n++) begin
         r = $urandom;
         ins_in = $urandom;
         if (r[2:0] != 0) ins_in[31:26] = ops[$urandom_range(0, 5)];
         if (r[4:3] == 0) ins_in[5:0] = 6'h0C;
         pc_in = $urandom;
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         halt_in = ($urandom_range(0, 99) == 0);
         clr = ($urandom_range(0, 49) == 0);
         wb_en = r[8];
         wb_addr = (r[11:9] == 0) ? 5'd2 : 5'($urandom_range(0, 31));
         wb_data = (r[13:12] == 0) ? HALT_V0 : $urandom;
         step();
      end
      stall = 0; flush = 0; halt_in = 0; wb_en = 0;

      // Syscall with $v0 == HALT_V0 halts and freezes the outputs
      clr = 1; step(); clr = 0;
      wb_en = 1; wb_addr = 5'd2; wb_data = HALT_V0; ins_in = 32'h0;
      step();
      wb_en = 0; ins_in = 32'h0000000C; pc_in = 32'h40;
      step();
      chk("sys_halt", {31'd0, halt}, 32'd1);
      chk("sys_ins", ins_out, 32'h0000000C);
      ins_in = 32'h2008FFFF; pc_in = 32'h44; wb_en = 1; wb_addr = 5'd5;
      wb_data = 32'h55;
      step(); step();
      wb_en = 0;
      chk("halt_frozen_ins", ins_out, 32'h0000000C);
      chk("halt_frozen_pc", pc_out, 32'h40);
      clr = 1; step(); clr = 0;
      chk("halt_cleared", {31'd0, halt}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
